// File: rtl/bit_logic_pkg.sv
// Shared definitions for the bitwise logic unit and anything else that reuses
// its combinational core (e.g. the ALU).
//   op_t    : 3-bit op select as carried on in_op
//   op_e    : named op encodings OP_AND..OP_NOTA
//   flags_t : status flags derived from a result (zero, ones, parity, neg)
package bit_logic_pkg;

    typedef logic [2:0] op_t;

    typedef enum op_t {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,  // A & ~B
        OP_NOTA = 3'd7   // ~A, B ignored
    } op_e;

    typedef struct packed {
        logic zero;    // result == 0
        logic ones;    // result is all ones
        logic parity;  // XOR-reduction of result
        logic neg;     // result MSB
    } flags_t;

endpackage

// File: rtl/bit_logic_core.sv
// Purely combinational bitwise operator with result flags.
//   a, b  : WIDTH-bit operands (sign-agnostic)
//   op    : operation select (op_e encoding)
//   res   : WIDTH-bit result
//   flags : zero / ones / parity / neg of res
module bit_logic_core
    import bit_logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] res,
    output flags_t           flags
);

    always_comb begin
        // NOTE: default assignment first so every path drives res and no latch is inferred.
        res = '0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_XNOR: res = ~(a ^ b);
            OP_ANDN: res = a & ~b;
            OP_NOTA: res = ~a;
            default: res = '0;
        endcase
    end

    always_comb begin
        flags.zero   = (res == '0);
        flags.ones   = &res;
        flags.parity = ^res;
        flags.neg    = res[WIDTH-1];
    end

endmodule

// File: rtl/bit_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control and an
// optional accumulator that can stand in for operand A.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake
//   in_a, in_b, in_op     : operands and op select
//   in_acc_sel            : 1 = take operand A from the accumulator
//   acc_clr               : clear accumulator at the next edge
//   out_valid / out_ready : result handshake
//   out_res               : result; out_zero/out_ones/out_parity/out_neg flags
module bit_logic_unit
    import bit_logic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  op_t              in_op,
    input  logic             in_acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic             out_neg
);

    logic             rst_done;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_t              s1_op;
    logic             s1_acc_sel;
    logic             s2_valid;
    flags_t           s2_flags;
    logic [WIDTH-1:0] acc;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] core_res;
    flags_t           core_flags;

    // Stage 2 can take a new entry when empty or when its result leaves this cycle;
    // stage 1 can take one when empty or when it moves into stage 2.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    // rst_done keeps the unit closed until the first edge after reset release.
    assign in_ready = rst_done && (!s1_valid || s2_adv);

    // The accumulator always holds the result of the op that last left S1,
    // so an acc_sel entry directly behind it chains without a bubble.
    assign op_a = s1_acc_sel ? acc : s1_a;

    bit_logic_core #(.WIDTH(WIDTH)) u_core (
        .a     (op_a),
        .b     (s1_b),
        .op    (s1_op),
        .res   (core_res),
        .flags (core_flags)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Stage 1: operand capture. When in_ready is high the slot is free at the
    // edge (empty or draining), so it simply takes whatever is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_AND;
            s1_acc_sel <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a       <= in_a;
                s1_b       <= in_b;
                s1_op      <= in_op;
                s1_acc_sel <= ACC_EN && in_acc_sel;
            end
        end
    end

    // Stage 2: result and flags. Payload only changes when a new entry arrives,
    // so out_res and flags hold while stalled and after the last result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_res  <= '0;
            s2_flags <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                out_res  <= core_res;
                s2_flags <= core_flags;
            end
        end
    end

    // Clear wins over a same-edge update; without ACC_EN it stays at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (ACC_EN) begin
            if (acc_clr) begin
                acc <= '0;
            end else if (s1_adv) begin
                acc <= core_res;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_zero   = s2_flags.zero;
    assign out_ones   = s2_flags.ones;
    assign out_parity = s2_flags.parity;
    assign out_neg    = s2_flags.neg;

endmodule

// File: tb/tb_bit_logic_unit.sv
// Self-checking bench for bit_logic_unit: directed vectors, stall, accumulator
// and reset sequences on a WIDTH=16 instance, and randomized traffic against a
// truth-table reference model on a WIDTH=8, ACC_EN=0 instance.
module tb_bit_logic_unit;
    import bit_logic_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance with accumulator
    logic        in_valid, in_ready, in_acc_sel, acc_clr;
    logic        out_valid, out_ready, out_zero, out_ones, out_parity, out_neg;
    logic [15:0] in_a, in_b, out_res;
    logic [2:0]  in_op;

    // 8-bit instance without accumulator
    logic        i8_valid, i8_ready, i8_acc_sel, a8_clr;
    logic        o8_valid, o8_ready, o8_zero, o8_ones, o8_parity, o8_neg;
    logic [7:0]  i8_a, i8_b, o8_res;
    logic [2:0]  i8_op;

    bit_logic_unit #(.WIDTH(16), .ACC_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc_sel(in_acc_sel),
        .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity), .out_neg(out_neg)
    );

    bit_logic_unit #(.WIDTH(8), .ACC_EN(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i8_valid), .in_ready(i8_ready),
        .in_a(i8_a), .in_b(i8_b), .in_op(i8_op), .in_acc_sel(i8_acc_sel),
        .acc_clr(a8_clr),
        .out_valid(o8_valid), .out_ready(o8_ready), .out_res(o8_res),
        .out_zero(o8_zero), .out_ones(o8_ones), .out_parity(o8_parity), .out_neg(o8_neg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Directed vector: operands, op, acc_sel, expected result and {zero,ones,parity,neg}.
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        sel;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs[13];

    // Reference: each op is its 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [11:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [3:0] tt;
        logic [7:0] r;
        int         ones;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0100;
            default: tt = 4'b0011;
        endcase
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            r[i] = tt[{a[i], b[i]}];
            ones += int'(r[i]);
        end
        return {r, (r == 8'h00), (r == 8'hFF), (ones % 2 == 1), r[7]};
    endfunction

    // Single op through an otherwise idle pipeline with out_ready high:
    // checks 2-cycle latency, result and flags.
    task automatic run_vec(input vec_t v, input string tag);
        int waited;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_op = v.op; in_acc_sel = v.sel; in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            fail_now({tag, " accept timeout"});
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0; in_acc_sel = 1'b0;
        check({tag, " latency 1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, " latency 2"}, 64'(out_valid), 64'd1);
        check({tag, " res"}, 64'(out_res), 64'(v.res));
        check({tag, " flags"}, 64'({out_zero, out_ones, out_parity, out_neg}), 64'(v.flg));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        int          sent, got, cyc, quiet;
        logic [11:0] e;
        logic [11:0] exp_q[$];

        vecs[0]  = '{16'd10,   16'd15,   3'd0, 1'b0, 16'h000A, 4'b0000};
        vecs[1]  = '{16'd10,   16'd15,   3'd1, 1'b0, 16'h000F, 4'b0000};
        vecs[2]  = '{16'd10,   16'd15,   3'd2, 1'b0, 16'h0005, 4'b0000};
        vecs[3]  = '{16'd25,   16'hFFE2, 3'd0, 1'b0, 16'h0000, 4'b1000};
        vecs[4]  = '{16'd25,   16'hFFE2, 3'd1, 1'b0, 16'hFFFB, 4'b0011};
        vecs[5]  = '{16'd25,   16'hFFE2, 3'd2, 1'b0, 16'hFFFB, 4'b0011};
        vecs[6]  = '{16'd25,   16'd25,   3'd2, 1'b0, 16'h0000, 4'b1000};
        vecs[7]  = '{16'h0000, 16'h1234, 3'd7, 1'b0, 16'hFFFF, 4'b0101};
        vecs[8]  = '{16'h00FF, 16'h0F0F, 3'd3, 1'b0, 16'hFFF0, 4'b0001};
        vecs[9]  = '{16'h00FF, 16'h0F0F, 3'd4, 1'b0, 16'hF000, 4'b0001};
        vecs[10] = '{16'h00FF, 16'h0F0F, 3'd5, 1'b0, 16'hF00F, 4'b0001};
        vecs[11] = '{16'h00FF, 16'h0F0F, 3'd6, 1'b0, 16'h00F0, 4'b0000};
        vecs[12] = '{16'h0007, 16'h0000, 3'd2, 1'b0, 16'h0007, 4'b0010};

        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_acc_sel = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b1;
        i8_valid = 1'b0; i8_a = '0; i8_b = '0; i8_op = '0; i8_acc_sel = 1'b0; a8_clr = 1'b0;
        o8_ready = 1'b1;

        // Reset state
        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_res", 64'(out_res), 64'd0);
        check("reset flags", 64'({out_zero, out_ones, out_parity, out_neg}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);
        check("out_valid after reset", 64'(out_valid), 64'd0);

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall: two accepted, third refused, results in order once released
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h00FF; in_op = OP_AND;
        @(negedge clk);
        in_a = 16'h1200; in_b = 16'h0034; in_op = OP_OR;
        @(negedge clk);
        in_a = 16'hFFFF; in_b = 16'h1234; in_op = OP_XOR;
        #1;
        check("stall third refused", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("stall ready %0d", i), 64'(in_ready), 64'd0);
            check($sformatf("stall valid %0d", i), 64'(out_valid), 64'd1);
            check($sformatf("stall hold %0d", i), 64'(out_res), 64'h0034);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release ready", 64'(in_ready), 64'd1);
        check("release res A", 64'(out_res), 64'h0034);
        @(negedge clk);
        in_valid = 1'b0;
        check("release res B", 64'({out_valid, out_res}), {47'd0, 1'b1, 16'h1234});
        @(negedge clk);
        check("release res C", 64'({out_valid, out_res}), {47'd0, 1'b1, 16'hEDCB});
        @(negedge clk);
        check("drained hold", 64'({out_valid, out_res}), {47'd0, 1'b0, 16'hEDCB});

        // Accumulator chain, back-to-back, with clear overriding an update
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        in_valid = 1'b1; in_acc_sel = 1'b1; in_a = 16'hDEAD; in_b = 16'h00F0; in_op = OP_OR;
        #1;
        check("acc ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_a = 16'hBEEF; in_b = 16'h00FF; in_op = OP_XOR;
        @(negedge clk);
        check("acc OR", 64'({out_valid, out_res}), {47'd0, 1'b1, 16'h00F0});
        in_a = 16'h1111; in_b = 16'hFFFF; in_op = OP_AND; acc_clr = 1'b1;
        @(negedge clk);
        check("acc XOR chain", 64'({out_valid, out_res}), {47'd0, 1'b1, 16'h000F});
        in_valid = 1'b0; in_acc_sel = 1'b0; acc_clr = 1'b0;
        @(negedge clk);
        check("acc cleared AND", 64'({out_valid, out_res}), {47'd0, 1'b1, 16'h0000});

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h0000; in_op = OP_OR;
        @(negedge clk);
        in_a = 16'hFFFF; in_b = 16'h00FF; in_op = OP_AND;
        @(negedge clk);
        in_valid = 1'b0;
        check("full before reset", 64'({out_valid, out_res}), {47'd0, 1'b1, 16'h0F0F});
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset out_res", 64'(out_res), 64'd0);
        check("async reset flags", 64'({out_zero, out_ones, out_parity, out_neg}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check("no stray output after reset", 64'(quiet), 64'd0);
        v = '{16'h5555, 16'h0000, 3'd1, 1'b1, 16'h0000, 4'b1000};
        run_vec(v, "acc after reset");

        // Randomized traffic on the 8-bit, no-accumulator instance
        sent = 0; got = 0; cyc = 0;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            o8_ready = ($urandom_range(0, 3) != 0);
            if (sent < 1000) begin
                i8_valid   = ($urandom_range(0, 2) != 0);
                i8_a       = 8'($urandom);
                i8_b       = 8'($urandom);
                i8_op      = 3'($urandom);
                i8_acc_sel = 1'($urandom);
                a8_clr     = 1'($urandom);
            end else begin
                i8_valid = 1'b0;
            end
            #1;
            if (o8_valid && o8_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("rand unexpected output");
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rand res #%0d", got), 64'(o8_res), 64'(e[11:4]));
                    check($sformatf("rand flags #%0d", got),
                          64'({o8_zero, o8_ones, o8_parity, o8_neg}), 64'(e[3:0]));
                    got++;
                end
            end
            if (i8_valid && i8_ready) begin
                exp_q.push_back(ref8(i8_a, i8_b, i8_op));
                sent++;
            end
        end
        check("rand sent", 64'(sent), 64'd1000);
        check("rand received", 64'(got), 64'd1000);
        check("rand drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_logic_unit.md
Name: bit_logic_unit

Overview:
Parametrised, pipelined bitwise logic unit. It is the successor to the standalone BIT_AND, BIT_OR and BIT_XOR blocks. One unit executes eight bitwise ops on WIDTH-bit operands and returns the result with status flags. It adds valid/ready flow control and an internal accumulator, so ops can be chained without the datapath re-supplying operand A.

Parameters:
WIDTH, 16, operand/result width in bits (legal range 2..64).
ACC_EN, 1, 1 = accumulator present; 0 = acc_sel and acc_clr are ignored and A always comes from in_a.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit accepts request this cycle
in_a  input  WIDTH  operand A (signed or unsigned; bitwise ops are sign-agnostic)
in_b  input  WIDTH  operand B
in_op  input  3  op select (see Behaviour)
in_acc_sel  input  1  1 = use accumulator as operand A
acc_clr  input  1  synchronous accumulator clear
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_res  output  WIDTH  result
out_zero  output  1  out_res == 0
out_ones  output  1  out_res all ones
out_parity  output  1  XOR-reduction of out_res
out_neg  output  1  out_res[WIDTH-1]

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid, s2_valid, out_valid = 0.
  - out_res and all flags = 0.
  - Accumulator = 0.
  - in_ready = 1 one cycle after rst_n deasserts.
- Op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 ANDN (A & ~B), 7 NOTA (~A; B ignored).
- Pipeline has two register stages:
  - S1 captures in_a, in_b, in_op and in_acc_sel.
  - S2 captures result and flags, computed combinationally from S1.
  - Latency is exactly 2 cycles from the input handshake to out_valid with no stall.
  - Throughput is 1 op/cycle.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational; no dependence on in_valid).
- Stall: when out_ready is low, S2 holds out_res and all flags stable, and S1 holds. Up to 2 accepted requests are buffered; a third is refused (in_ready = 0).
- Ordering: results leave strictly in acceptance order. No drop, no duplication.
- Accumulator:
  - Updated with the S2 result on every s1_adv edge.
  - When the S1 entry has acc_sel = 1, operand A = the current accumulator value. This equals the result of the immediately preceding op, so back-to-back chaining needs no bubble.
  - acc_clr sets the accumulator to 0 at the next edge and overrides a same-cycle update.
  - acc_clr does not affect in-flight S1/S2 data or out_res.
- Flags are derived from the S2 result and registered with it, so they are always consistent with out_res.
- out_valid falls after the handshake when no new result is loaded in the same cycle. out_res then holds its last value.
- Reset mid-operation: all in-flight entries are discarded with no output handshake. The accumulator returns to 0.

Decomposition:
- Package bit_logic_pkg holds:
  - the op enum/localparams OP_AND..OP_NOTA;
  - a 3-bit op typedef;
  - the flag struct (zero, ones, parity, neg).
- One combinational sub-module, bit_logic_core:
  - inputs (a, b, op); outputs (res, flags);
  - parametrised by WIDTH;
  - reusable by the ALU.
- bit_logic_unit contains the handshake, pipeline registers and accumulator.

Test Plan:
1. WIDTH=16, out_ready=1: (10,15) AND/OR/XOR -> 0x000A / 0x000F / 0x0005, each 2 cycles after acceptance. XOR parity=0.
2. (25,-30) AND -> 0x0000 zero=1. OR -> 0xFFFB neg=1, parity=1. XOR -> 0xFFFB. (25,25) XOR -> 0x0000 zero=1. NOTA(0) -> 0xFFFF ones=1.
3. Stall: hold out_ready=0 and offer 3 back-to-back ops. The first two are accepted; in_ready=0 on the third; out_res stays stable. Release out_ready -> three results in order on consecutive cycles.
4. Accumulator chain: acc_clr; OR acc_sel B=0x00F0 -> 0x00F0; then XOR acc_sel B=0x00FF back-to-back -> 0x000F; then acc_clr with an op in the same cycle -> next acc_sel AND B=0xFFFF -> 0x0000.
5. Reset mid-operation: assert rst_n=0 with both stages full -> out_valid=0 asynchronously, out_res=0, no stray handshake after release. Accumulator read via acc_sel OR B=0 -> 0x0000.
6. WIDTH=8, ACC_EN=0: random ops against a reference model with randomised in_valid/out_ready. acc_sel=1 must not change results (A comes from in_a). No loss or reorder over 1000 ops.
